// File: rtl/scan_chain_sink_pkg.sv
// Shared types and sizing helpers for the scan chain tail deserialiser.
package scan_chain_sink_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit counter only needs to index 0..width-1; keep at least one bit.
  function automatic int bitcnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_BITCNT_W = bitcnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/scan_chain_sink_obuf.sv
// One-entry valid/ready output register with overflow detect and a
// delivered-word counter.
module scan_chain_sink_obuf
  import scan_chain_sink_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             word_valid_i,
  input  logic             ready_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             xfer;
  logic             drop;

  // Handshake: a word moves when valid and ready are both high at a rising
  // edge; Q is held stable while valid is high and ready is low.
  assign xfer = valid_q & ready_i;

  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    drop    = 1'b0;
    if (word_valid_i && (!valid_q || ready_i)) begin
      q_d     = word_i;
      valid_d = 1'b1;
    end else begin
      if (word_valid_i) drop = 1'b1;
      if (xfer) valid_d = 1'b0;
    end
  end

  // New events win over a same-cycle clear; a transfer under clear counts as one.
  always_comb begin
    ovf_d   = drop ? 1'b1 : (clr_i ? 1'b0 : ovf_q);
    count_d = count_q;
    if (xfer)       count_d = clr_i ? CNT_W'(1) : count_q + CNT_W'(1);
    else if (clr_i) count_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign q_o       = q_q;
  assign q_valid_o = valid_q;
  assign ovf_o     = ovf_q;
  assign count_o   = count_q;

endmodule

// File: rtl/scan_chain_sink.sv
// Scan chain tail: samples SI while SE is high, deserialises LSB-first into
// WIDTH-bit words and hands them to a one-entry valid/ready output register.
module scan_chain_sink
  import scan_chain_sink_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SE,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic             OVF,
  output logic             PART,
  input  logic             CLR,
  output logic [CNT_W-1:0] COUNT
);

  localparam int             BCW      = bitcnt_width(WIDTH);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             part_set;
  logic             part_q, part_d;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    word      = shreg_q;
    word_done = 1'b0;
    part_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (SE) begin
          word    = '0;
          word[0] = SI;
          state_d = SHIFT;
          if (WIDTH == 1) begin
            word_done = 1'b1;
            shreg_d   = '0;
            bitcnt_d  = '0;
          end else begin
            shreg_d  = word;
            bitcnt_d = BCW'(1);
          end
        end
      end
      SHIFT: begin
        if (SE) begin
          word[bitcnt_q] = SI;
          // Completing a word keeps us in SHIFT so the next word can follow directly.
          if (bitcnt_q == LAST_IDX) begin
            word_done = 1'b1;
            shreg_d   = '0;
            bitcnt_d  = '0;
          end else begin
            shreg_d  = word;
            bitcnt_d = bitcnt_q + BCW'(1);
          end
        end else begin
          state_d  = IDLE;
          shreg_d  = '0;
          bitcnt_d = '0;
          if (bitcnt_q != '0) part_set = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        shreg_d  = '0;
        bitcnt_d = '0;
      end
    endcase
    part_d = part_set ? 1'b1 : (CLR ? 1'b0 : part_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      part_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      part_q   <= part_d;
    end
  end

  assign PART = part_q;

  scan_chain_sink_obuf #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_obuf (
    .clk_i       (CLK),
    .rst_i       (RST),
    .word_i      (word),
    .word_valid_i(word_done),
    .ready_i     (Q_READY),
    .clr_i       (CLR),
    .q_o         (Q),
    .q_valid_o   (Q_VALID),
    .ovf_o       (OVF),
    .count_o     (COUNT)
  );

endmodule

// File: tb/tb_scan_chain_sink.sv
// Directed bench for scan_chain_sink: default instance plus a CNT_W=2
// instance for counter wrap.
module tb_scan_chain_sink;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          se, si, q_ready, clr;
  logic [W-1:0]  q, q2;
  logic          q_valid, ovf, part;
  logic          q_valid2, ovf2, part2;
  logic [15:0]   count;
  logic [1:0]    count2;

  int            tests_run = 0;
  int            fails     = 0;
  int            vhi       = 0;
  bit            mon_en    = 1'b0;
  logic [W-1:0]  exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  scan_chain_sink #(.WIDTH(W), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .SE(se), .SI(si), .Q(q), .Q_VALID(q_valid),
    .Q_READY(q_ready), .OVF(ovf), .PART(part), .CLR(clr), .COUNT(count)
  );

  scan_chain_sink #(.WIDTH(W), .CNT_W(2)) dut2 (
    .CLK(clk), .RST(rst), .SE(se), .SI(si), .Q(q2), .Q_VALID(q_valid2),
    .Q_READY(q_ready), .OVF(ovf2), .PART(part2), .CLR(clr), .COUNT(count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs read 1ns after the rising edge.
  task automatic send_bit(input logic b);
    @(negedge clk);
    se = 1'b1;
    si = b;
    @(posedge clk);
    #1;
    if (q_valid) vhi++;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_bit(w[i]);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    se = 1'b0;
    si = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cycle();
    @(negedge clk);
    se  = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Scoreboard: every transfer must match the next expected word.
  always begin
    @(negedge clk);
    #2;
    if (mon_en && q_valid && q_ready) begin
      if (exp_q.size() == 0) check("xfer_unexpected", 32'd1, 32'd0);
      else check("xfer_word", 32'(q), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; se = 1'b0; si = 1'b0; q_ready = 1'b0; clr = 1'b0;
    #1;
    check("rst_q", 32'(q), 32'h0);
    check("rst_valid", 32'(q_valid), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_flags", {30'd0, ovf, part}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single word 4D with ready high
    q_ready = 1'b1;
    mon_en  = 1'b1;
    exp_q.push_back(8'h4D);
    send_word(8'h4D);
    check("t1_q", 32'(q), 32'h4D);
    check("t1_valid", 32'(q_valid), 32'h1);
    check("t1_count_pre", 32'(count), 32'h0);
    idle_cycle();
    check("t1_count", 32'(count), 32'h1);
    check("t1_valid_clr", 32'(q_valid), 32'h0);
    mon_en = 1'b0;

    // 2: overflow with ready low
    q_ready = 1'b0;
    clr_cycle();
    check("t2_count_clr", 32'(count), 32'h0);
    send_word(8'hA5);
    check("t2_q_first", 32'(q), 32'hA5);
    send_word(8'h3C);
    check("t2_q_hold", 32'(q), 32'hA5);
    check("t2_ovf", 32'(ovf), 32'h1);
    check("t2_valid", 32'(q_valid), 32'h1);
    @(negedge clk);
    se = 1'b0;
    q_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_count", 32'(count), 32'h1);
    check("t2_valid_clr", 32'(q_valid), 32'h0);
    check("t2_no_part", 32'(part), 32'h0);

    // 3: partial frame then full frame
    clr_cycle();
    check("t3_ovf_clr", 32'(ovf), 32'h0);
    check("t3_count_clr", 32'(count), 32'h0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    idle_cycle();
    check("t3_part", 32'(part), 32'h1);
    check("t3_valid", 32'(q_valid), 32'h0);
    send_word(8'hFF);
    check("t3_q", 32'(q), 32'hFF);
    check("t3_valid_full", 32'(q_valid), 32'h1);
    idle_cycle();
    check("t3_count", 32'(count), 32'h1);

    // 4: asynchronous reset on the third bit
    q_ready = 1'b0;
    send_word(8'h5A);
    check("t4_q_held", 32'(q), 32'h5A);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    se = 1'b1;
    si = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("t4_async_q", 32'(q), 32'h0);
    check("t4_async_valid", 32'(q_valid), 32'h0);
    check("t4_async_count", 32'(count), 32'h0);
    check("t4_async_flags", {30'd0, ovf, part}, 32'h0);
    @(negedge clk);
    se  = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t4_part_after", 32'(part), 32'h0);
    check("t4_valid_after", 32'(q_valid), 32'h0);

    // 5: continuous streaming, CLR on the 4th transfer
    q_ready = 1'b1;
    vhi     = 0;
    mon_en  = 1'b1;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h78);
    send_word(8'h12);
    send_word(8'h34);
    send_word(8'h56);
    send_word(8'h78);
    check("t5_q_last", 32'(q), 32'h78);
    check("t5_count3", 32'(count), 32'h3);
    check("t5_ovf", 32'(ovf), 32'h0);
    check("t5_valid_cycles", 32'(vhi), 32'd4);
    @(negedge clk);
    se  = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("t5_count_clr_xfer", 32'(count), 32'h1);
    check("t5_valid_clr", 32'(q_valid), 32'h0);
    @(negedge clk);
    clr    = 1'b0;
    mon_en = 1'b0;
    check("t5_exp_empty", 32'(exp_q.size()), 32'd0);

    // 6: CNT_W=2 wrap
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [W-1:0] w;
      w = W'(8'hC0 + k);
      send_word(w);
      idle_cycle();
      check($sformatf("t6_count2_%0d", k), 32'(count2), 32'((k + 1) % 4));
      check($sformatf("t6_count_%0d", k), 32'(count), 32'(k + 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
